sdf_delay_line: RTL
===================

Name: sdf_delay_line

Overview:
Valid-qualified, run-time programmable delay line for the single-path delay-feedback (SDF) DIF FFT stages. It generalises the fixed shift-register delay into a RAM-backed circular buffer:
- depth is selectable per FFT size, from 1 to MAX_DEPTH;
- the buffer advances only on accepted samples, so upstream bubbles do not corrupt butterfly pairing.

It sits between the BFU output and its feedback input, one instance per stage.

Parameters:
- BIT_WIDTH, 32, data width in bits (packed re/im).
- MAX_DEPTH, 64, maximum delay in accepted samples; storage entries.
- DEFAULT_DEPTH, 64, depth loaded at reset; must be in 1..MAX_DEPTH.
- DEPTH_W, $clog2(MAX_DEPTH+1), localparam, width of depth/count fields.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- cfg_load  in  1  pulse: apply cfg_depth and flush.
- cfg_depth  in  DEPTH_W  requested delay.
- in_valid  in  1  sample accept strobe.
- in_data  in  BIT_WIDTH  sample.
- out_valid  out  1  out_data holds a delayed sample.
- out_data  out  BIT_WIDTH  delayed sample.
- primed  out  1  buffer full at current depth.
- cfg_err  out  1  sticky: illegal cfg_depth seen.
- parity_err  out  1  sticky storage parity error (see Optional Feature).

Behaviour:
- Interface: one clock, clk; reset is asynchronous, active-low, reset_n.
- Reset values:
  - out_valid=0, out_data=0, primed=0, cfg_err=0, parity_err=0.
  - wr_ptr=0, fill_cnt=0, depth_r=DEFAULT_DEPTH, state=FILL.
  - Storage array is not reset.
- State machine:
  - FILL: on each accept, fill_cnt increments; when fill_cnt reaches depth_r-1 on an accept, go to RUN.
  - RUN: primed=1; stays until cfg_load or reset.
- Accept (in_valid=1, cfg_load=0):
  - Read mem[wr_ptr] before writing, then write in_data to mem[wr_ptr].
  - wr_ptr increments and wraps to 0 after depth_r-1 (not MAX_DEPTH-1).
  - In RUN, the read value is registered to out_data and out_valid=1 the next cycle.
- No accept: out_valid=0 next cycle; out_data holds its previous value.
- Latency: the sample of accept k appears on out_data the cycle after accept k+depth_r. With continuous in_valid this is depth_r+1 cycles.
- Output count: the first depth_r accepts after reset or flush produce no output.
- cfg_load (priority over in_valid):
  - A same-cycle sample is discarded.
  - wr_ptr=0, fill_cnt=0, state=FILL, primed=0, out_valid=0 next cycle.
  - depth_r=cfg_depth if it is in 1..MAX_DEPTH. Otherwise depth_r=MAX_DEPTH (0 also maps to MAX_DEPTH) and cfg_err is set.
  - cfg_err clears only on reset.
- depth_r=1: FILL exits on the first accept (fill_cnt compare at 0). Output equals the previous accepted sample.
- Reset mid-stream: all state returns to reset values immediately. Stale RAM contents are never output, because out_valid requires RUN.

Optional Feature:
- Macro SDF_DELAY_LINE_PARITY_EN.
- Defined:
  - Each entry stores BIT_WIDTH+1 bits; the extra bit is even parity of in_data.
  - On every RUN read, parity is recomputed. A mismatch sets sticky parity_err in the same cycle out_valid rises.
  - Data still passes through unchanged.
- Undefined: storage is BIT_WIDTH wide and parity_err is tied 0.

Decomposition:
- Shared package fft_buf_pkg:
  - state encoding (FILL=1'b0, RUN=1'b1);
  - a clog2 helper function;
  - the parity function.
- Sub-module sdf_dly_ram: MAX_DEPTH-entry single-port read-before-write RAM, synchronous write, registered read. This module owns pointer, count, FSM and the error flags.

Test Plan:
- Depth from reset: DEFAULT_DEPTH=64, in_valid continuous, in_data=0,1,2,… → first out_valid after 65 cycles with out_data=0, then consecutive values, no gaps.
- Bubbles: cfg_depth=4, in_valid pattern 1,0,1,1,0,0,1,1,1,… with data 10,11,12,… on accepts → outputs start on the 5th accept, sequence 10,11,…; out_valid only the cycle after accepts.
- Reconfigure mid-stream: run at depth 8, pulse cfg_load with cfg_depth=2 and in_valid=1 → that sample is dropped, primed drops, next 2 accepts produce no output, 3rd accept outputs the first post-load sample.
- Illegal depths: cfg_load with cfg_depth=0, then MAX_DEPTH+1 → cfg_err=1 (sticky), depth_r=MAX_DEPTH, latency MAX_DEPTH+1.
- Async reset: assert reset_n=0 mid-RUN, between clock edges → out_valid, primed and out_data go to 0 immediately. After release, no output until DEFAULT_DEPTH accepts.
- Parity (with SDF_DELAY_LINE_PARITY_EN): force one stored bit flipped at depth 4 → parity_err=1 on that sample's out_valid cycle and stays 1. Without the macro, parity_err=0 throughout.

Source files
------------

// File: rtl/fft_buf_pkg.sv
// Shared definitions for the FFT stage buffers: delay-line state encoding,
// a constant-evaluable ceil(log2) helper and the even-parity function used
// by the optional storage protection (macro SDF_DELAY_LINE_PARITY_EN).
package fft_buf_pkg;

  // Delay-line control state: filling the buffer, or emitting delayed samples.
  typedef enum logic [0:0] {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } dly_state_e;

  // Widest word the parity helper accepts; callers zero-extend into it.
  localparam int unsigned PAR_MAX_W = 256;

  // ceil(log2(value)); usable in parameter/localparam expressions.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 32'd0;
    for (int i = 0; i < 32; i++) begin
      if (((value - 32'd1) >> i) != 32'd0) r = unsigned'(i) + 32'd1;
    end
    return r;
  endfunction

  // Even parity bit: makes the total number of ones (data + bit) even.
  // Zero-extension of narrower data does not change the result.
  function automatic logic even_parity(input logic [PAR_MAX_W-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/sdf_dly_ram.sv
// Single-port read-before-write storage for sdf_delay_line.
// Synchronous write, registered read; the read register is the delay-line
// output stage, so it is reset while the array itself is not.
// With SDF_DELAY_LINE_PARITY_EN defined each entry carries an extra even
// parity bit and the read port also registers a parity-mismatch flag.
module sdf_dly_ram
  import fft_buf_pkg::*;
#(
  parameter  int unsigned BIT_WIDTH = 32,
  parameter  int unsigned MAX_DEPTH = 64,
  localparam int unsigned ADDR_W    = (MAX_DEPTH > 32'd1) ? clog2(MAX_DEPTH) : 32'd1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_we,
  input  logic                 i_rd_en,
  input  logic [ADDR_W-1:0]    i_addr,
  input  logic [BIT_WIDTH-1:0] i_wdata,
  output logic [BIT_WIDTH-1:0] o_rdata
`ifdef SDF_DELAY_LINE_PARITY_EN
  ,
  output logic                 o_rd_bad
`endif
);

`ifdef SDF_DELAY_LINE_PARITY_EN
  localparam int unsigned MEM_W = BIT_WIDTH + 32'd1;
`else
  localparam int unsigned MEM_W = BIT_WIDTH;
`endif

  logic [MEM_W-1:0]     r_mem [MAX_DEPTH];
  logic [MEM_W-1:0]     w_wword;
  logic [MEM_W-1:0]     w_rword;
  logic [BIT_WIDTH-1:0] r_rdata;

  assign w_rword = r_mem[i_addr];
  assign o_rdata = r_rdata;

`ifdef SDF_DELAY_LINE_PARITY_EN
  logic [PAR_MAX_W-1:0] w_wdata_ext;
  logic [PAR_MAX_W-1:0] w_rdata_ext;
  logic                 w_rd_mismatch;
  logic                 r_rd_bad;

  assign w_wdata_ext   = {{(PAR_MAX_W-BIT_WIDTH){1'b0}}, i_wdata};
  assign w_rdata_ext   = {{(PAR_MAX_W-BIT_WIDTH){1'b0}}, w_rword[BIT_WIDTH-1:0]};
  assign w_wword       = {even_parity(w_wdata_ext), i_wdata};
  assign w_rd_mismatch = even_parity(w_rdata_ext) != w_rword[BIT_WIDTH];
  assign o_rd_bad      = r_rd_bad;

  // Parity check result travels with the registered read word.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_bad <= 1'b0;
    end else if (i_rd_en) begin
      r_rd_bad <= w_rd_mismatch;
    end
  end
`else
  assign w_wword = i_wdata;
`endif

  // Registered read port: captures the old word before this cycle's write lands.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rdata <= {BIT_WIDTH{1'b0}};
    end else if (i_rd_en) begin
      r_rdata <= w_rword[BIT_WIDTH-1:0];
    end
  end

  // Storage array: synchronous write, deliberately not reset.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_addr] <= w_wword;
    end
  end

endmodule

// File: rtl/sdf_delay_line.sv
// Run-time programmable, valid-qualified delay line for an SDF FFT stage.
// A circular buffer of r_depth entries advances only on accepted samples;
// output starts once the buffer has been filled at the current depth.
// Optional storage parity: define SDF_DELAY_LINE_PARITY_EN.
module sdf_delay_line
  import fft_buf_pkg::*;
#(
  parameter  int unsigned BIT_WIDTH     = 32,
  parameter  int unsigned MAX_DEPTH     = 64,
  parameter  int unsigned DEFAULT_DEPTH = 64,
  localparam int unsigned DEPTH_W       = clog2(MAX_DEPTH + 32'd1)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cfg_load,
  input  logic [DEPTH_W-1:0]   cfg_depth,
  input  logic                 in_valid,
  input  logic [BIT_WIDTH-1:0] in_data,
  output logic                 out_valid,
  output logic [BIT_WIDTH-1:0] out_data,
  output logic                 primed,
  output logic                 cfg_err,
  output logic                 parity_err
);

  localparam int unsigned      ADDR_W = (MAX_DEPTH > 32'd1) ? clog2(MAX_DEPTH) : 32'd1;
  localparam logic [DEPTH_W-1:0] MAX_D = DEPTH_W'(MAX_DEPTH);
  localparam logic [DEPTH_W-1:0] DEF_D = DEPTH_W'(DEFAULT_DEPTH);
  localparam logic [DEPTH_W-1:0] ONE_D = DEPTH_W'(32'd1);
  localparam logic [DEPTH_W-1:0] ZERO_D = DEPTH_W'(32'd0);

  dly_state_e         r_state;
  dly_state_e         w_state_nxt;
  logic [DEPTH_W-1:0] r_wr_ptr;
  logic [DEPTH_W-1:0] r_fill_cnt;
  logic [DEPTH_W-1:0] r_depth;
  logic               r_cfg_err;
  logic               r_out_valid;
  logic               w_accept;
  logic               w_run;
  logic               w_rd_en;
  logic               w_last_slot;
  logic               w_fill_done;
  logic               w_depth_legal;

  // cfg_load wins over a same-cycle sample, which is simply dropped.
  assign w_accept      = in_valid & ~cfg_load;
  assign w_rd_en       = w_accept & w_run;
  assign w_last_slot   = (r_wr_ptr == (r_depth - ONE_D));
  assign w_fill_done   = (r_fill_cnt == (r_depth - ONE_D));
  assign w_depth_legal = (cfg_depth != ZERO_D) && (cfg_depth <= MAX_D);

  assign out_valid = r_out_valid;
  assign primed    = w_run;
  assign cfg_err   = r_cfg_err;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: leave FILL on the accept that completes the buffer.
  always_comb begin
    w_state_nxt = r_state;
    if (cfg_load) begin
      w_state_nxt = ST_FILL;
    end else begin
      case (r_state)
        ST_FILL: begin
          if (w_accept && w_fill_done) w_state_nxt = ST_RUN;
          else                         w_state_nxt = ST_FILL;
        end
        ST_RUN:  w_state_nxt = ST_RUN;
        default: w_state_nxt = ST_FILL;
      endcase
    end
  end

  // State outputs: RUN means the buffer is primed and reads are real samples.
  always_comb begin
    w_run = 1'b0;
    case (r_state)
      ST_RUN:  w_run = 1'b1;
      ST_FILL: w_run = 1'b0;
      default: w_run = 1'b0;
    endcase
  end

  // Write pointer wraps at the programmed depth; fill count tracks FILL progress.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr   <= ZERO_D;
      r_fill_cnt <= ZERO_D;
    end else if (cfg_load) begin
      r_wr_ptr   <= ZERO_D;
      r_fill_cnt <= ZERO_D;
    end else if (w_accept) begin
      r_wr_ptr <= w_last_slot ? ZERO_D : (r_wr_ptr + ONE_D);
      if (!w_run) begin
        r_fill_cnt <= r_fill_cnt + ONE_D;
      end
    end
  end

  // Depth register; illegal requests fall back to the full buffer and latch cfg_err.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_depth   <= DEF_D;
      r_cfg_err <= 1'b0;
    end else if (cfg_load) begin
      if (w_depth_legal) begin
        r_depth <= cfg_depth;
      end else begin
        r_depth   <= MAX_D;
        r_cfg_err <= 1'b1;
      end
    end
  end

  // out_valid marks the cycle after an accept made while running.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= w_rd_en;
    end
  end

`ifdef SDF_DELAY_LINE_PARITY_EN
  logic w_rd_bad;
  logic r_parity_err;

  sdf_dly_ram #(
    .BIT_WIDTH (BIT_WIDTH),
    .MAX_DEPTH (MAX_DEPTH)
  ) u_ram (
    .i_clk    (clk),
    .i_rst_n  (reset_n),
    .i_we     (w_accept),
    .i_rd_en  (w_rd_en),
    .i_addr   (r_wr_ptr[ADDR_W-1:0]),
    .i_wdata  (in_data),
    .o_rdata  (out_data),
    .o_rd_bad (w_rd_bad)
  );

  // Sticky parity flag; the OR below makes it visible with the bad sample itself.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_parity_err <= 1'b0;
    end else if (r_out_valid && w_rd_bad) begin
      r_parity_err <= 1'b1;
    end
  end

  assign parity_err = r_parity_err | (r_out_valid & w_rd_bad);
`else
  sdf_dly_ram #(
    .BIT_WIDTH (BIT_WIDTH),
    .MAX_DEPTH (MAX_DEPTH)
  ) u_ram (
    .i_clk   (clk),
    .i_rst_n (reset_n),
    .i_we    (w_accept),
    .i_rd_en (w_rd_en),
    .i_addr  (r_wr_ptr[ADDR_W-1:0]),
    .i_wdata (in_data),
    .o_rdata (out_data)
  );

  assign parity_err = 1'b0;
`endif

endmodule
